// File: rtl/otter_fetch_queue.sv
// Instruction fetch for OTTER memory port 1: sequential PC generation, one in-flight
// synchronous read, and a small tagged queue toward decode with zero-bubble redirect.
module otter_fetch_queue #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] MEM_BYTES = 32'h0000_4000
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [31:0] MEM_ADDR1,
    output logic        MEM_READ1,
    input  logic [31:0] MEM_DOUT1,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IF_VALID,
    input  logic        ID_READY,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_IR,
    output logic        IF_ERR
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= MEM_BYTES);
    endfunction

    logic [31:0]   fpc_q, fpc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic          rsp_err_q, rsp_err_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] q_pc_q  [DEPTH];
    logic [31:0] q_ir_q  [DEPTH];
    logic        q_err_q [DEPTH];

    logic        head_valid;
    logic        pop_req;
    logic        pop;
    logic        push;
    logic        issue;
    logic [31:0] occ;

    assign head_valid = (count_q != '0);
    assign pop_req    = head_valid && ID_READY;
    // A redirect flushes the queue, so that cycle's pop and push are both void.
    assign pop        = pop_req && !REDIRECT;
    assign push       = rsp_valid_q && !REDIRECT;

    // Occupancy once the in-flight response lands and the head leaves.
    assign occ   = 32'(count_q) + 32'(rsp_valid_q) - 32'(pop_req);
    assign issue = RST_N && (REDIRECT || (occ < DEPTH));

    assign MEM_READ1 = issue;
    assign MEM_ADDR1 = (RST_N && REDIRECT) ? REDIRECT_PC : fpc_q;

    assign IF_VALID = head_valid;
    assign IF_PC    = head_valid ? q_pc_q[rd_ptr_q]  : 32'h0;
    assign IF_IR    = head_valid ? q_ir_q[rd_ptr_q]  : 32'h0;
    assign IF_ERR   = head_valid ? q_err_q[rd_ptr_q] : 1'b0;

    always_comb begin
        fpc_d       = fpc_q;
        rsp_valid_d = 1'b0;
        rsp_pc_d    = rsp_pc_q;
        rsp_err_d   = rsp_err_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (REDIRECT) begin
            fpc_d       = REDIRECT_PC + 32'd4;
            rsp_valid_d = 1'b1;
            rsp_pc_d    = REDIRECT_PC;
            rsp_err_d   = addr_err(REDIRECT_PC);
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
        end else begin
            if (issue) begin
                fpc_d       = fpc_q + 32'd4;
                rsp_valid_d = 1'b1;
                rsp_pc_d    = fpc_q;
                rsp_err_d   = addr_err(fpc_q);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fpc_q       <= RESET_VEC;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= 32'h0;
            rsp_err_q   <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fpc_q       <= fpc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_err_q   <= rsp_err_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_pc_q[wr_ptr_q]  <= rsp_pc_q;
            q_ir_q[wr_ptr_q]  <= MEM_DOUT1;
            q_err_q[wr_ptr_q] <= rsp_err_q;
        end
    end

    assert property (@(posedge CLK) disable iff (!RST_N) !(push && (count_q == CW'(DEPTH))));
    assert property (@(posedge CLK) disable iff (!RST_N) !(pop && (count_q == '0)));

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue with a synchronous-read instruction memory model.
module tb_otter_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IF_VALID;
    logic        ID_READY;
    logic [31:0] IF_PC;
    logic [31:0] IF_IR;
    logic        IF_ERR;

    int checks = 0;
    int errors = 0;

    otter_fetch_queue #(
        .RESET_VEC (32'h0000_0000),
        .DEPTH     (2),
        .MEM_BYTES (32'h0000_4000)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .MEM_ADDR1   (MEM_ADDR1),
        .MEM_READ1   (MEM_READ1),
        .MEM_DOUT1   (MEM_DOUT1),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .IF_VALID    (IF_VALID),
        .ID_READY    (ID_READY),
        .IF_PC       (IF_PC),
        .IF_IR       (IF_IR),
        .IF_ERR      (IF_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memw(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            default: return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    logic [31:0] mem_dout = 32'h0;
    always @(posedge CLK) begin
        if (MEM_READ1) mem_dout <= memw(MEM_ADDR1);
    end
    assign MEM_DOUT1 = mem_dout;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                        input logic err);
        chk1({tag, "_valid"}, IF_VALID, 1'b1);
        chk32({tag, "_pc"}, IF_PC, pc);
        chk32({tag, "_ir"}, IF_IR, ir);
        chk1({tag, "_err"}, IF_ERR, err);
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle after release).
    task automatic restart();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N       = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        ID_READY    = 1'b0;

        sample();
        chk1("rst_valid", IF_VALID, 1'b0);
        chk1("rst_read", MEM_READ1, 1'b0);
        chk32("rst_addr", MEM_ADDR1, 32'h0);
        chk32("rst_pc", IF_PC, 32'h0);

        // Streaming with ID_READY high, then redirects.
        ID_READY = 1'b1;
        tick();
        RST_N = 1'b1;
        sample();                                   // c0
        chk1("s_c0_read", MEM_READ1, 1'b1);
        chk32("s_c0_addr", MEM_ADDR1, 32'h0);
        chk1("s_c0_valid", IF_VALID, 1'b0);
        tick(); sample();                           // c1
        chk1("s_c1_valid", IF_VALID, 1'b0);
        chk32("s_c1_addr", MEM_ADDR1, 32'h4);
        tick(); sample();                           // c2
        head("s_c2", 32'h0, 32'h0000_0013, 1'b0);
        tick(); sample();                           // c3
        head("s_c3", 32'h4, 32'h0010_0093, 1'b0);
        tick();                                     // c4: redirect with count=1
        REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
        sample();
        head("s_c4", 32'h8, 32'h0020_0113, 1'b0);
        chk32("rd_addr", MEM_ADDR1, 32'h100);
        chk1("rd_read", MEM_READ1, 1'b1);
        tick(); REDIRECT = 1'b0; sample();          // c5
        chk1("rd_c5_valid", IF_VALID, 1'b0);
        chk32("rd_c5_addr", MEM_ADDR1, 32'h104);
        tick(); sample();                           // c6
        head("rd_c6", 32'h100, 32'hDEAD_0100, 1'b0);
        tick(); sample();                           // c7
        head("rd_c7", 32'h104, 32'hDEAD_0104, 1'b0);
        tick();                                     // c8: misaligned target
        REDIRECT = 1'b1; REDIRECT_PC = 32'h102;
        sample();
        tick(); REDIRECT = 1'b0; sample();          // c9
        chk1("mis_c9_valid", IF_VALID, 1'b0);
        tick();                                     // c10: out-of-range target
        REDIRECT = 1'b1; REDIRECT_PC = 32'h4000;
        sample();
        head("mis_c10", 32'h102, 32'hDEAD_0102, 1'b1);
        tick(); REDIRECT = 1'b0; sample();          // c11
        chk1("oor_c11_valid", IF_VALID, 1'b0);
        tick();                                     // c12: last legal word
        REDIRECT = 1'b1; REDIRECT_PC = 32'h3FFC;
        sample();
        head("oor_c12", 32'h4000, 32'hDEAD_4000, 1'b1);
        tick(); REDIRECT = 1'b0; sample();          // c13
        chk1("edge_c13_valid", IF_VALID, 1'b0);
        tick(); sample();                           // c14
        head("edge_c14", 32'h3FFC, 32'hDEAD_3FFC, 1'b0);
        tick(); sample();                           // c15
        head("edge_c15", 32'h4000, 32'hDEAD_4000, 1'b1);

        // Backpressure: queue fills and drains without gap, duplicate or loss.
        restart();                                  // c0
        tick();                                     // c1
        tick(); ID_READY = 1'b0; sample();          // c2
        chk1("bp_c2_read", MEM_READ1, 1'b0);
        head("bp_c2", 32'h0, 32'h0000_0013, 1'b0);
        tick(); sample();                           // c3
        chk1("bp_c3_read", MEM_READ1, 1'b0);
        tick(); sample();                           // c4
        chk1("bp_c4_read", MEM_READ1, 1'b0);
        chk32("bp_c4_pc", IF_PC, 32'h0);
        tick(); ID_READY = 1'b1; sample();          // c5
        chk1("bp_c5_read", MEM_READ1, 1'b1);
        chk32("bp_c5_addr", MEM_ADDR1, 32'h8);
        head("bp_c5", 32'h0, 32'h0000_0013, 1'b0);
        tick(); sample();                           // c6
        head("bp_c6", 32'h4, 32'h0010_0093, 1'b0);
        tick(); sample();                           // c7
        head("bp_c7", 32'h8, 32'h0020_0113, 1'b0);
        tick(); sample();                           // c8
        head("bp_c8", 32'hC, 32'hDEAD_000C, 1'b0);

        // Asynchronous reset with a full queue.
        restart();                                  // c0
        tick();                                     // c1
        tick(); ID_READY = 1'b0;                    // c2
        tick(); sample();                           // c3: count=2
        chk1("ar_full_read", MEM_READ1, 1'b0);
        tick(); ID_READY = 1'b1;                    // c4
        #2;
        chk1("ar_pre_valid", IF_VALID, 1'b1);
        chk1("ar_pre_read", MEM_READ1, 1'b1);
        #1 RST_N = 1'b0;
        #2;
        chk1("ar_valid", IF_VALID, 1'b0);
        chk1("ar_read", MEM_READ1, 1'b0);
        chk32("ar_addr", MEM_ADDR1, 32'h0);
        tick();
        tick();
        RST_N = 1'b1;                               // c0
        sample();
        chk1("ar_c0_read", MEM_READ1, 1'b1);
        chk32("ar_c0_addr", MEM_ADDR1, 32'h0);
        tick(); sample();                           // c1
        chk1("ar_c1_valid", IF_VALID, 1'b0);
        tick(); sample();                           // c2
        head("ar_c2", 32'h0, 32'h0000_0013, 1'b0);

        // Redirect coinciding with a push and a pop.
        tick();                                     // c3
        REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
        sample();
        head("pp_c3", 32'h4, 32'h0010_0093, 1'b0);
        chk32("pp_c3_addr", MEM_ADDR1, 32'h200);
        tick(); REDIRECT = 1'b0; sample();          // c4
        chk1("pp_c4_valid", IF_VALID, 1'b0);
        tick(); sample();                           // c5
        head("pp_c5", 32'h200, 32'hDEAD_0200, 1'b0);
        tick(); sample();                           // c6
        head("pp_c6", 32'h204, 32'hDEAD_0204, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
